// File: rtl/hazard_scoreboard_if.sv
// Decode/execute/writeback signal bundle for the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned RW = 5
);
    logic          issue_valid;
    logic [RW-1:0] issue_rd;
    logic          issue_regwrite;
    logic          issue_is_load;
    logic [RW-1:0] rs1_d;
    logic [RW-1:0] rs2_d;
    logic          flush_d;
    logic          flush_e;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic          stall_d;
    logic          load_use;
    logic          busy_rs1;
    logic          busy_rs2;
    logic          e_valid;
    logic [RW-1:0] e_rd;
    logic          e_regwrite;
    logic          e_is_load;
    logic          err_underflow;

    // Scoreboard side
    modport slave (
        input  issue_valid, issue_rd, issue_regwrite, issue_is_load,
        input  rs1_d, rs2_d, flush_d, flush_e, wb_valid, wb_rd,
        output stall_d, load_use, busy_rs1, busy_rs2,
        output e_valid, e_rd, e_regwrite, e_is_load, err_underflow
    );

    // Pipeline side
    modport master (
        output issue_valid, issue_rd, issue_regwrite, issue_is_load,
        output rs1_d, rs2_d, flush_d, flush_e, wb_valid, wb_rd,
        input  stall_d, load_use, busy_rs1, busy_rs2,
        input  e_valid, e_rd, e_regwrite, e_is_load, err_underflow
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes, holds the D->E control fields and
// stalls decode on load-use or pending-write counter saturation.
module hazard_scoreboard #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
) (
    input logic              clk,
    input logic              rst,
    hazard_scoreboard_if.slave bus
);
    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned SW = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             e_valid_q, e_valid_d;
    logic [RW-1:0]    e_rd_q, e_rd_d;
    logic             e_regwrite_q, e_regwrite_d;
    logic             e_is_load_q, e_is_load_d;
    logic             err_q, err_d;

    logic             d_tracks, e_tracks;
    logic             load_use, sat_stall, stall, accept;
    logic             inc, dec_wb, dec_fl;
    logic [SW-1:0]    up, down;

    // Hazard detection from registered state and the decode instruction
    always_comb begin
        d_tracks  = bus.issue_regwrite && (bus.issue_rd != '0);
        e_tracks  = e_valid_q && e_regwrite_q && (e_rd_q != '0);
        load_use  = bus.issue_valid && e_tracks && e_is_load_q &&
                    ((e_rd_q == bus.rs1_d) || (e_rd_q == bus.rs2_d));
        sat_stall = bus.issue_valid && d_tracks && (cnt_q[bus.issue_rd] == CNT_MAX);
        stall     = !bus.flush_d && (load_use || sat_stall);
        accept    = bus.issue_valid && !bus.flush_d && !stall;
    end

    assign bus.stall_d       = stall;
    assign bus.load_use      = load_use;
    assign bus.busy_rs1      = (bus.rs1_d != '0) && (cnt_q[bus.rs1_d] != '0);
    assign bus.busy_rs2      = (bus.rs2_d != '0) && (cnt_q[bus.rs2_d] != '0);
    assign bus.e_valid       = e_valid_q;
    assign bus.e_rd          = e_rd_q;
    assign bus.e_regwrite    = e_regwrite_q;
    assign bus.e_is_load     = e_is_load_q;
    assign bus.err_underflow = err_q;

    // Per-register net update; a net decrement below zero clamps and flags
    always_comb begin
        err_d    = err_q;
        cnt_d[0] = '0;
        inc      = 1'b0;
        dec_wb   = 1'b0;
        dec_fl   = 1'b0;
        up       = '0;
        down     = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            inc    = accept && d_tracks && (bus.issue_rd == RW'(r));
            dec_wb = bus.wb_valid && (bus.wb_rd == RW'(r));
            dec_fl = bus.flush_e && e_tracks && (e_rd_q == RW'(r));
            up     = SW'(cnt_q[r]) + SW'(inc);
            down   = SW'(dec_wb) + SW'(dec_fl);
            if (up < down) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(up - down);
            end
        end
    end

    // E stage: load on accept, otherwise insert a bubble
    always_comb begin
        e_valid_d    = accept;
        e_rd_d       = accept ? bus.issue_rd : '0;
        e_regwrite_d = accept && bus.issue_regwrite;
        e_is_load_d  = accept && bus.issue_is_load;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            e_valid_q    <= 1'b0;
            e_rd_q       <= '0;
            e_regwrite_q <= 1'b0;
            e_is_load_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            e_valid_q    <= e_valid_d;
            e_rd_q       <= e_rd_d;
            e_regwrite_q <= e_regwrite_d;
            e_is_load_q  <= e_is_load_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a counting model.
module tb_hazard_scoreboard;
    localparam int MAXP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;

    hazard_scoreboard_if bus ();

    hazard_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes per register and the E-stage slot
    int cnt_m [32];
    bit ev_m, ereg_m, eload_m, err_m;
    int erd_m;

    function automatic logic [12:0] dut_outs();
        return {bus.stall_d, bus.load_use, bus.busy_rs1, bus.busy_rs2, bus.e_valid,
                bus.e_rd, bus.e_regwrite, bus.e_is_load, bus.err_underflow};
    endfunction

    function automatic bit m_load_use();
        return bus.issue_valid && ev_m && eload_m && ereg_m && erd_m != 0 &&
               (erd_m == int'(bus.rs1_d) || erd_m == int'(bus.rs2_d));
    endfunction

    function automatic bit m_stall();
        bit sat;
        sat = bus.issue_valid && bus.issue_regwrite && bus.issue_rd != 0 &&
              cnt_m[bus.issue_rd] == MAXP;
        return !bus.flush_d && (m_load_use() || sat);
    endfunction

    function automatic logic [12:0] exp_outs();
        bit b1, b2;
        b1 = bus.rs1_d != 0 && cnt_m[bus.rs1_d] > 0;
        b2 = bus.rs2_d != 0 && cnt_m[bus.rs2_d] > 0;
        return {m_stall(), m_load_use(), b1, b2, ev_m, 5'(erd_m), ereg_m, eload_m, err_m};
    endfunction

    task automatic model_tick();
        bit acc;
        int n;
        if (rst) begin
            for (int r = 0; r < 32; r++) cnt_m[r] = 0;
            ev_m = 0; erd_m = 0; ereg_m = 0; eload_m = 0; err_m = 0;
        end else begin
            acc = bus.issue_valid && !bus.flush_d && !m_stall();
            for (int r = 1; r < 32; r++) begin
                n = cnt_m[r];
                if (acc && bus.issue_regwrite && int'(bus.issue_rd) == r) n++;
                if (bus.wb_valid && int'(bus.wb_rd) == r) n--;
                if (bus.flush_e && ev_m && ereg_m && erd_m == r) n--;
                if (n < 0) begin
                    n = 0;
                    err_m = 1;
                end
                cnt_m[r] = n;
            end
            ev_m    = acc;
            erd_m   = acc ? int'(bus.issue_rd) : 0;
            ereg_m  = acc && bus.issue_regwrite;
            eload_m = acc && bus.issue_is_load;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        cyc++;
        #1;
    endtask

    task automatic drive(input bit iv, input int rd, input bit rw, input bit ld,
                         input int r1, input int r2, input bit fd, input bit fe,
                         input bit wv, input int wrd);
        bus.issue_valid    = iv;
        bus.issue_rd       = 5'(rd);
        bus.issue_regwrite = rw;
        bus.issue_is_load  = ld;
        bus.rs1_d          = 5'(r1);
        bus.rs2_d          = 5'(r2);
        bus.flush_d        = fd;
        bus.flush_e        = fe;
        bus.wb_valid       = wv;
        bus.wb_rd          = 5'(wrd);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        total_cnt++;
        if (dut_outs() !== 13'd0) $display("FAIL reset_outs got %b exp %b", dut_outs(), 13'd0);
        else pass_cnt++;
        for (int r = 1; r < 32; r++) begin
            drive(0, 0, 0, 0, r, r, 0, 0, 0, 0);
            total_cnt++;
            if ({bus.busy_rs1, bus.busy_rs2} !== 2'b00)
                $display("FAIL reset_busy r%0d got %b exp 00", r, {bus.busy_rs1, bus.busy_rs2});
            else pass_cnt++;
        end
    endtask

    task automatic test_load_use();
        drive(1, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (dut_outs() !== exp_outs()) $display("FAIL lu_issue got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
        drive(1, 6, 1, 0, 5, 0, 0, 0, 0, 0);
        total_cnt++;
        if ({bus.stall_d, bus.load_use} !== 2'b11 || dut_outs() !== exp_outs())
            $display("FAIL lu_stall got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.e_valid, bus.stall_d, bus.busy_rs1} !== 3'b001 || dut_outs() !== exp_outs())
            $display("FAIL lu_bubble got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 5, 0, 0, 0, 1, 5);
        total_cnt++;
        if (bus.busy_rs1 !== 1'b1 || dut_outs() !== exp_outs())
            $display("FAIL lu_wb_nobypass got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 5, 6, 0, 0, 1, 6);
        total_cnt++;
        if ({bus.busy_rs1, bus.busy_rs2} !== 2'b01 || dut_outs() !== exp_outs())
            $display("FAIL lu_after_wb got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
            total_cnt++;
            if (bus.stall_d !== 1'b0 || dut_outs() !== exp_outs())
                $display("FAIL sat_fill%0d got %b exp %b", i, dut_outs(), exp_outs());
            else pass_cnt++;
            tick();
        end
        drive(1, 7, 1, 0, 7, 0, 0, 0, 0, 0);
        total_cnt++;
        if ({bus.stall_d, bus.load_use, bus.busy_rs1} !== 3'b101 || dut_outs() !== exp_outs())
            $display("FAIL sat_stall got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
        drive(1, 7, 1, 0, 0, 0, 0, 0, 1, 7);
        total_cnt++;
        if (bus.stall_d !== 1'b1 || dut_outs() !== exp_outs())
            $display("FAIL sat_stall_with_wb got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (bus.stall_d !== 1'b0 || dut_outs() !== exp_outs())
            $display("FAIL sat_release got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 7, 0, 0, 0, 1, 7);
            tick();
        end
        drive(0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        total_cnt++;
        if (bus.busy_rs1 !== 1'b0 || dut_outs() !== exp_outs())
            $display("FAIL sat_drain got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
    endtask

    task automatic test_triple_event();
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 9, 1, 0, 9, 0, 0, 1, 1, 9);
        total_cnt++;
        if ({bus.stall_d, bus.busy_rs1} !== 2'b01 || dut_outs() !== exp_outs())
            $display("FAIL triple_pre got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 9, 0, 0, 0, 0, 0);
        total_cnt++;
        if ({bus.busy_rs1, bus.e_valid, bus.e_rd} !== {2'b01, 5'd9} || dut_outs() !== exp_outs())
            $display("FAIL triple_post got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
    endtask

    task automatic test_underflow();
        drive(0, 0, 0, 0, 12, 0, 0, 0, 1, 12);
        total_cnt++;
        if (bus.err_underflow !== 1'b0) $display("FAIL uf_pre got %b exp 0", bus.err_underflow);
        else pass_cnt++;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 12, 0, 0, 0, 0, 0);
            total_cnt++;
            if ({bus.err_underflow, bus.busy_rs1} !== 2'b10 || dut_outs() !== exp_outs())
                $display("FAIL uf_sticky%0d got %b exp %b", i, dut_outs(), exp_outs());
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_x0_and_flush_d();
        drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if ({bus.stall_d, bus.load_use, bus.busy_rs1} !== 3'b000 || dut_outs() !== exp_outs())
            $display("FAIL x0_nostall got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
        drive(1, 4, 1, 1, 0, 3, 0, 0, 0, 0);
        tick();
        drive(1, 3, 1, 0, 4, 3, 1, 0, 0, 0);
        total_cnt++;
        if ({bus.stall_d, bus.load_use, bus.busy_rs2} !== 3'b011 || dut_outs() !== exp_outs())
            $display("FAIL flushd_mask got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        total_cnt++;
        if ({bus.e_valid, bus.busy_rs2} !== 2'b01 || dut_outs() !== exp_outs())
            $display("FAIL flushd_noissue got %b exp %b", dut_outs(), exp_outs());
        else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7));
            total_cnt++;
            if (dut_outs() !== exp_outs())
                $display("FAIL rand cyc%0d got %b exp %b", cyc, dut_outs(), exp_outs());
            else pass_cnt++;
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 2, 2, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        total_cnt++;
        if (dut_outs() !== 13'd0) $display("FAIL mid_reset got %b exp %b", dut_outs(), 13'd0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_saturation();
        test_triple_event();
        test_underflow();
        test_reset();
        test_x0_and_flush_d();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX-stage forwarding logic. It tracks every in-flight register write from decode issue to writeback.
- It also holds the D->E stage control fields (rd, regwrite, is_load) that forwarding compares against.
- It detects load-use hazards and per-register pending-write overflow, and stalls decode for either.
- It sits between decode and execute and receives writeback and branch-flush events.

Parameters:
- NREG, 32, number of architectural registers (x0 is hard-wired zero and never tracked).
- CNT_W, 2, width of each per-register pending-write counter; max pending = 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode presents an instruction for issue into E this cycle
- issue_rd  in  5  destination of decode instruction
- issue_regwrite  in  1  decode instruction writes issue_rd
- issue_is_load  in  1  decode instruction is a load
- rs1_d  in  5  decode source 1
- rs2_d  in  5  decode source 2
- flush_d  in  1  kill the decode instruction (no issue)
- flush_e  in  1  kill the instruction currently held in E
- wb_valid  in  1  a register write retires this cycle
- wb_rd  in  5  register written at writeback
- stall_d  out  1  hold PC/IF-ID; decode instruction not accepted
- load_use  out  1  load-use component of stall_d
- busy_rs1  out  1  pending count of rs1_d nonzero
- busy_rs2  out  1  pending count of rs2_d nonzero
- e_valid  out  1  E stage holds a live instruction
- e_rd  out  5  E-stage destination
- e_regwrite  out  1  E-stage regwrite
- e_is_load  out  1  E-stage load flag
- err_underflow  out  1  sticky: writeback/flush seen on a zero counter

Behaviour:
- A decode instruction "tracks" when issue_regwrite=1 and issue_rd!=0. The E-stage instruction tracks when e_valid & e_regwrite & e_rd!=0.
- load_use (combinational from registered state) = issue_valid & e_valid & e_is_load & e_regwrite & e_rd!=0 & (e_rd==rs1_d | e_rd==rs2_d).
- sat_stall = issue_valid & decode instruction tracks & cnt[issue_rd]==max.
- stall_d = ~flush_d & (load_use | sat_stall). flush_d masks stall_d to 0.
- accept = issue_valid & ~flush_d & ~stall_d.
- E register, per rising edge, in priority order:
  - rst: clear all E fields.
  - accept: load issue fields, e_valid=1 (this also replaces a flushed E entry).
  - Otherwise: e_valid=0 (bubble on stall, flush_e, or no issue), other fields don't-care/0.
- Counters, rising edge: cnt[r] <= cnt[r] + inc - dec_wb - dec_fl.
  - inc = accept & decode instruction tracks & issue_rd==r.
  - dec_wb = wb_valid & wb_rd==r & r!=0.
  - dec_fl = flush_e & E instruction tracks & e_rd==r.
  - All three may hit the same register in one cycle; the net sum is applied. Example: cnt=1, inc+wb+flush -> cnt 0.
- Underflow: a decrement that would take cnt below 0 clamps cnt to 0 and sets err_underflow. err_underflow is cleared only by rst.
- Overflow is impossible: sat_stall blocks inc at max, and a simultaneous dec on a saturated reg still stalls (conservative).
- busy_rs1/busy_rs2 read the registered counters. There is no same-cycle bypass of wb or flush; the register file's write-first path covers the writeback case. rs==0 -> busy=0.
- Latency: a counter changes one cycle after its event; load_use deasserts the cycle after the load leaves E.
- Reset (sync, rst=1): all cnt=0, e_valid=0, e_rd=0, e_regwrite=0, e_is_load=0, err_underflow=0. Combinational outputs therefore read 0. Reset mid-operation discards all pending state with no decrement events.
- x0 is never counted, never stalls, and is never busy.

Test Plan:
- Reset then idle -> all outputs 0; cnt[1..31]=0.
- Issue load rd=5; next cycle issue add rs1=5 -> load_use=1, stall_d=1 for one cycle, e_valid=0 the following cycle; the add is accepted the cycle after; cnt[5]=1 until wb_rd=5, then busy_rs1 for rs1=5 reads 0.
- Issue three writes to rd=7 back-to-back without wb (CNT_W=2) -> cnt[7]=3; a fourth write to rd=7 gives stall_d=1, load_use=0; wb_rd=7 -> next cycle cnt=2 and the fourth issues.
- E holds write rd=9 (cnt=1); same cycle flush_e=1, wb_rd=9, and accepted issue rd=9 -> cnt[9]=0 next cycle, e_rd=9, e_valid=1.
- wb_valid with wb_rd=12 while cnt[12]=0 -> cnt stays 0, err_underflow=1 and holds until rst.
- Issue with issue_rd=0, load in E with e_rd=0 and rs1_d=0 -> no stall, cnt unchanged; flush_d=1 during a load_use condition -> stall_d=0 and no issue.
